line_memory: RTL

Backing main-memory model answering the instruction and data caches' line-fill and write-back requests. Serves 4-word (64-bit) line reads on the port-1 channel (readM1/address1/data1/read_ack) and line writes on the port-2 channel (writeM2/address2/data2/write_ack) with a fixed, parameterised access latency. It sits outside the cpu top level and is the responder end of the cache-to-memory interface used in the testbench.

---
 rtl/line_memory.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/line_memory.sv
// ---------------------------------------------------------------------------
// line_memory
//
// Backing main-memory model that answers the caches' line-fill and
// write-back traffic. Memory is organised as 16-bit words, transferred four
// at a time (one 64-bit line). Every accepted request completes after a
// fixed, parameterised latency.
//
// Parameters:
//   MEM_WORDS  memory depth in 16-bit words (power of 2, multiple of 4, >= 8)
//   LATENCY    access latency in cycles (1..15)
//
// Ports:
//   Clk        clock, all state changes on the rising edge
//   Reset      synchronous active-high reset (memory contents are kept)
//   readM1     line-read request, held high until read_ack
//   address1   read word address, bits [1:0] ignored
//   data1      read line, word base+i on bits [16i+15:16i]
//   read_ack   one-cycle pulse, data1 valid
//   writeM2    line-write request, held high until write_ack
//   address2   write word address, bits [1:0] ignored
//   data2      write line, same packing as data1
//   write_ack  one-cycle pulse, line committed
// ---------------------------------------------------------------------------
module line_memory #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        readM1,
    input  logic [15:0] address1,
    output logic [63:0] data1,
    output logic        read_ack,
    input  logic        writeM2,
    input  logic [15:0] address2,
    input  logic [63:0] data2,
    output logic        write_ack
);

    localparam int             LINES     = MEM_WORDS / 4;
    localparam int             LINE_BITS = $clog2(MEM_WORDS) - 2;
    localparam logic [3:0]     CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [LINE_BITS-1:0]   r_line;
    logic [63:0]            r_wdata;
    logic                   r_read_ack;
    logic                   r_write_ack;

    logic                   w_rd_fire;
    logic                   w_wr_fire;
    logic                   w_unused;

    // Completion happens only while the owning request is still held; a
    // dropped request takes the abort path in the FSM instead.
    assign w_rd_fire = (r_state == READ)  && readM1  && (r_cnt == 4'd0);
    assign w_wr_fire = (r_state == WRITE) && writeM2 && (r_cnt == 4'd0);

    // Line offset bits and the address bits above the memory size are
    // intentionally ignored (addresses wrap modulo MEM_WORDS).
    assign w_unused = ^{address1, address2};

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_line      <= '0;
            r_wdata     <= '0;
            r_read_ack  <= 1'b0;
            r_write_ack <= 1'b0;
        end else begin
            r_read_ack  <= 1'b0;
            r_write_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Write-back must land before a refill of the same line.
                    if (writeM2) begin
                        r_state <= WRITE;
                        r_line  <= address2[LINE_BITS+1:2];
                        r_wdata <= data2;
                        r_cnt   <= CNT_LOAD;
                    end else if (readM1) begin
                        r_state <= READ;
                        r_line  <= address1[LINE_BITS+1:2];
                        r_cnt   <= CNT_LOAD;
                    end
                end
                READ: begin
                    if (!readM1) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_read_ack <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (!writeM2) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_write_ack <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Requests still high during the ack cycle are ignored
                    // here so they are not served twice.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one bank per word position of the line, so a whole line is
    // written or read in a single cycle. data1 is the registered read port.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [15:0] r_mem [LINES];
            logic [15:0] r_rd_word;

            always_ff @(posedge Clk) begin
                if (w_wr_fire && !Reset) begin
                    r_mem[r_line] <= r_wdata[16*gi +: 16];
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_rd_word <= 16'd0;
                end else if (w_rd_fire) begin
                    r_rd_word <= r_mem[r_line];
                end
            end

            assign data1[16*gi +: 16] = r_rd_word;
        end
    endgenerate

    assign read_ack  = r_read_ack;
    assign write_ack = r_write_ack;

endmodule
